pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Generic parametrised pipeline stage register. Successor to the fixed-field inter-stage registers between pipeline stages.
- Carries an opaque data payload plus a control field, with a valid/ready handshake for stalls and a synchronous flush for hazards and branches.
- An optional skid entry breaks the combinational ready path.
- Instantiated between any two stages, e.g. EX→MEM, with ctrl carrying MemRead/MemWrite/MemtoReg/RegWrite.

Parameters:
- DATA_W, 37: payload width (e.g. ALU result 32 + dest reg 5). Data is not cleared on a bubble.
- CTRL_W, 4: control width. Forced to zero whenever the stage holds no valid entry.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage accepts an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main-entry payload.
- out_ctrl  out  CTRL_W  main-entry control; 0 when out_valid=0.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Reset (reset=0, asynchronous): main_valid=0, skid_valid=0, all data/ctrl registers=0, occupancy=0. in_ready=1 (SKID=1), or 1 via its combinational equation (SKID=0).
- Transfer rules:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both are evaluated on the same edge.
- SKID=1:
  - in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
  - Main slot free (main empty or pop), skid valid: main←skid, skid emptied; any acc lands in main is impossible since in_ready=0.
  - Main slot free, skid empty, acc: main←input.
  - Main slot free, no source: main_valid←0, main ctrl←0.
  - Main held (no pop), acc: skid←input, skid_valid←1, so in_ready drops next cycle.
  - Order is preserved: skid always drains to main before any new input is taken.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - acc loads main. pop without acc empties main and clears ctrl.
  - Classic stall semantics: a held entry is stable while out_ready=0.
- Stall stability: while out_valid=1 and out_ready=0, out_data and out_ctrl do not change.
- Flush:
  - Highest priority after reset.
  - At the edge, main_valid=skid_valid=0, both ctrl registers ←0, and any simultaneous acc is discarded.
  - A pop in the flush cycle is still counted by downstream. The flush affects the next state only.
  - in_ready after flush is 1.
- Latency: 1 cycle from acc to out_valid when the stage is empty. Throughput is 1 entry/cycle with out_ready=1.
- occupancy = main_valid + skid_valid, registered.
- Data registers are not cleared on bubble or flush; they hold their last value. Only the ctrl fields are cleared.
- Reset asserted mid-transfer: all state clears immediately, independent of clk. No entry is produced after reset release until a new acc.

Test Plan:
- Reset → check out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. Stream 8 entries (data=i, ctrl=4'hF) with out_ready=1 → outputs data 0..7 in order, one per cycle, 1-cycle latency.
- SKID=1, out_ready=0, present entries A then B → A on out, B in skid, occupancy=2, in_ready=0. C is held upstream. Raise out_ready → A, B, C in order with no loss or duplicate.
- SKID=0 stall: hold out_ready=0 with entry A → out_data=A stable and in_ready=0. Release → next entry follows in the cycle after the pop.
- Flush with occupancy=2 and in_valid=1 in the same cycle → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, and the offered entry does not appear.
- Bubble: in_valid=0 for one cycle between entries (ctrl=4'b1010) → the bubble cycle shows out_valid=0 and out_ctrl=0, while out_data keeps its prior value.
- Assert reset asynchronously mid-cycle with occupancy=2 → outputs clear before the next clk edge. After release, the first entry out is the first new accepted one.

Source files
------------

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle between an upstream producer, a pipe_stage_buf and its downstream consumer.
// master = side driving the stage (producer/consumer harness), slave = the stage itself.
interface pipe_stage_buf_if #(
  parameter int unsigned DATA_W = 37,
  parameter int unsigned CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with valid/ready handshake, synchronous flush and
// an optional skid entry that registers in_ready to cut the combinational ready path.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 37,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned SKID   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  pipe_stage_buf_if.slave bus,
  output logic [1:0]      occupancy
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic              in_ready_q,   in_ready_d;
  logic [1:0]        occ_q,        occ_d;

  logic in_ready;
  logic acc;
  logic pop;
  logic main_free;

  assign in_ready  = (SKID != 0) ? in_ready_q : (!main_valid_q || bus.out_ready);
  assign acc       = bus.in_valid & in_ready;
  assign pop       = main_valid_q & bus.out_ready;
  assign main_free = !main_valid_q | pop;

  // Ctrl is zeroed whenever its slot empties; payload registers keep their last value.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (SKID != 0) begin
      if (main_free) begin
        if (skid_valid_q) begin
          main_valid_d = 1'b1;
          main_data_d  = skid_data_q;
          main_ctrl_d  = skid_ctrl_q;
          skid_valid_d = 1'b0;
          skid_ctrl_d  = '0;
        end else if (acc) begin
          main_valid_d = 1'b1;
          main_data_d  = bus.in_data;
          main_ctrl_d  = bus.in_ctrl;
        end else begin
          main_valid_d = 1'b0;
          main_ctrl_d  = '0;
        end
      end else if (acc) begin
        skid_valid_d = 1'b1;
        skid_data_d  = bus.in_data;
        skid_ctrl_d  = bus.in_ctrl;
      end
    end else begin
      if (acc) begin
        main_valid_d = 1'b1;
        main_data_d  = bus.in_data;
        main_ctrl_d  = bus.in_ctrl;
      end else if (pop) begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end

    // Ready is precomputed from the next skid state so it never depends on out_ready.
    in_ready_d = !skid_valid_d;
    occ_d      = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      in_ready_q   <= 1'b1;
      occ_q        <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      in_ready_q   <= in_ready_d;
      occ_q        <= occ_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives a skid (SKID=1) and a plain (SKID=0) stage with the same stimulus and compares
// each against a queue-based model of an in-order buffer of depth 2 / depth 1.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 37;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] occ1, occ0;

  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) bus1 ();
  pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) bus0 ();

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_s1 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus1.slave), .occupancy(occ1)
  );
  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_s0 (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus0.slave), .occupancy(occ0)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  ent_t          mq1[$];
  ent_t          mq0[$];
  logic [DW-1:0] hd1 = '0;
  logic [DW-1:0] hd0 = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    bus1.in_valid = v; bus1.in_data = d; bus1.in_ctrl = c; bus1.out_ready = ordy;
    bus0.in_valid = v; bus0.in_data = d; bus0.in_ctrl = c; bus0.out_ready = ordy;
    flush = fl;
  endtask

  task automatic check_all(input logic ordy);
    logic [CW-1:0] c1, c0;
    c1 = (mq1.size() != 0) ? mq1[0].c : '0;
    c0 = (mq0.size() != 0) ? mq0[0].c : '0;
    check_eq("s1.out_valid", 64'(bus1.out_valid), 64'(mq1.size() != 0));
    check_eq("s1.out_ctrl",  64'(bus1.out_ctrl),  64'(c1));
    check_eq("s1.out_data",  64'(bus1.out_data),  64'(hd1));
    check_eq("s1.occupancy", 64'(occ1),           64'(mq1.size()));
    check_eq("s1.in_ready",  64'(bus1.in_ready),  64'(mq1.size() < 2));
    check_eq("s0.out_valid", 64'(bus0.out_valid), 64'(mq0.size() != 0));
    check_eq("s0.out_ctrl",  64'(bus0.out_ctrl),  64'(c0));
    check_eq("s0.out_data",  64'(bus0.out_data),  64'(hd0));
    check_eq("s0.occupancy", 64'(occ0),           64'(mq0.size()));
    check_eq("s0.in_ready",  64'(bus0.in_ready),  64'((mq0.size() == 0) || ordy));
  endtask

  // One clock: drive at negedge, check, then advance the model to the next edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    ent_t e;
    bit acc1, pop1, acc0, pop0;
    @(negedge clk);
    drive(v, d, c, ordy, fl);
    #1;
    check_all(ordy);
    e.d  = d;
    e.c  = c;
    acc1 = v && (mq1.size() < 2);
    pop1 = (mq1.size() != 0) && ordy;
    acc0 = v && ((mq0.size() == 0) || ordy);
    pop0 = (mq0.size() != 0) && ordy;
    if (fl) begin
      mq1.delete();
      mq0.delete();
    end else begin
      if (pop1) void'(mq1.pop_front());
      if (acc1) mq1.push_back(e);
      if (pop0) void'(mq0.pop_front());
      if (acc0) mq0.push_back(e);
    end
    if (mq1.size() != 0) hd1 = mq1[0].d;
    if (mq0.size() != 0) hd0 = mq0[0].d;
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Streaming with downstream always ready
    for (int unsigned i = 0; i < 8; i++) cycle(1'b1, DW'(i), 4'hF, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Stall: A, B, then C offered while downstream blocked, then release
    cycle(1'b1, DW'(37'h0A), 4'h1, 1'b0, 1'b0);
    cycle(1'b1, DW'(37'h0B), 4'h2, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, DW'(37'h0C), 4'h3, 1'b0, 1'b0);
    cycle(1'b1, DW'(37'h0C), 4'h3, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush while full and offering a new entry
    cycle(1'b1, DW'(37'h11), 4'h5, 1'b0, 1'b0);
    cycle(1'b1, DW'(37'h12), 4'h6, 1'b0, 1'b0);
    cycle(1'b1, DW'(37'h13), 4'h7, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Bubble between entries
    cycle(1'b1, DW'(37'h21), 4'b1010, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, DW'(37'h22), 4'b1010, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomised traffic
    for (int unsigned i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, DW'({$urandom(), $urandom()}), CW'($urandom()),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset between edges while both stages hold entries
    cycle(1'b1, DW'(37'h31), 4'h9, 1'b0, 1'b0);
    cycle(1'b1, DW'(37'h32), 4'hA, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("rst.s1_valid", 64'(bus1.out_valid), 64'd0);
    check_eq("rst.s1_ctrl",  64'(bus1.out_ctrl),  64'd0);
    check_eq("rst.s1_data",  64'(bus1.out_data),  64'd0);
    check_eq("rst.s1_occ",   64'(occ1),           64'd0);
    check_eq("rst.s1_rdy",   64'(bus1.in_ready),  64'd1);
    check_eq("rst.s0_valid", 64'(bus0.out_valid), 64'd0);
    check_eq("rst.s0_occ",   64'(occ0),           64'd0);
    mq1.delete();
    mq0.delete();
    hd1 = '0;
    hd0 = '0;
    #1 reset = 1'b1;
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 4; i++) cycle(1'b1, DW'(37'h40 + i), 4'hC, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
